yarvi_wb: RTL and testbench

YARVI_WB -- requirements
Module: yarvi_wb

---
 rtl/yarvi_wb_pkg.sv | 22 ++
 rtl/yarvi_wb_counter.sv | 22 ++
 rtl/yarvi_wb.sv | 132 +++++++++++++
 tb/tb_yarvi_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yarvi_wb_pkg.sv
// Shared definitions for the YARVI write-back stage: FSM states, trap causes
// and the default restart address.
package yarvi_wb_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } wb_state_e;

    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] CAUSE_M_TIMER_IRQ      = 32'h8000_0007;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Direct-mode trap vector: the two mode bits of mtvec never reach the PC.
    function automatic logic [31:0] trap_vector(input logic [31:0] mtvec);
        return mtvec & ~32'h3;
    endfunction

endpackage

// File: rtl/yarvi_wb_counter.sv
// 64-bit retired-instruction counter with increment enable and async clear.
module yarvi_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // Wraps naturally from all-ones back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/yarvi_wb.sv
// YARVI write-back stage: retires ME results, raises traps and replays,
// and squashes the pipeline for a fixed number of cycles after each restart.
module yarvi_wb
    import yarvi_wb_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        me_valid,
    input  logic [31:0] me_pc,
    input  logic [4:0]  me_wb_rd,
    input  logic [31:0] me_wb_val,
    input  logic        me_store,
    input  logic        me_exc_misaligned,
    input  logic [31:0] me_exc_mtval,
    input  logic        me_load_hit_store,
    input  logic        me_timer_interrupt,

    input  logic        csr_mie,
    input  logic [31:0] csr_mtvec,

    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_val,
    output logic        wb_restart,
    output logic [31:0] wb_restart_pc,
    output logic        wb_trap,
    output logic [31:0] wb_mcause,
    output logic [31:0] wb_mepc,
    output logic [31:0] wb_mtval,
    output logic [63:0] wb_instret
);

    // At least one squash cycle keeps restart pulses from ever abutting.
    localparam int unsigned DEPTH = (FLUSH_DEPTH == 0) ? 1 : FLUSH_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    wb_state_e     r_state;
    logic [CW-1:0] r_flush_cnt;

    logic          w_run;
    logic          w_irq;
    logic          w_retire;

    assign w_run    = (r_state == ST_RUN);
    assign w_irq    = csr_mie & me_timer_interrupt & me_valid & ~me_store;
    assign w_retire = w_run & me_valid & ~me_exc_misaligned
                      & ~me_load_hit_store & ~w_irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_BOOT;
            r_flush_cnt   <= '0;
            wb_we         <= 1'b0;
            wb_rd         <= '0;
            wb_val        <= '0;
            wb_restart    <= 1'b0;
            wb_restart_pc <= '0;
            wb_trap       <= 1'b0;
            wb_mcause     <= '0;
            wb_mepc       <= '0;
            wb_mtval      <= '0;
        end else begin
            wb_we      <= 1'b0;
            wb_restart <= 1'b0;
            wb_trap    <= 1'b0;

            case (r_state)
                ST_BOOT: begin
                    wb_restart    <= 1'b1;
                    wb_restart_pc <= RESET_PC;
                    r_flush_cnt   <= CW'(DEPTH);
                    r_state       <= ST_FLUSH;
                end

                ST_RUN: begin
                    if (me_exc_misaligned) begin
                        wb_trap       <= 1'b1;
                        wb_mcause     <= me_store ? CAUSE_STORE_MISALIGNED
                                                  : CAUSE_LOAD_MISALIGNED;
                        wb_mepc       <= me_pc;
                        wb_mtval      <= me_exc_mtval;
                        wb_restart    <= 1'b1;
                        wb_restart_pc <= trap_vector(csr_mtvec);
                        r_flush_cnt   <= CW'(DEPTH);
                        r_state       <= ST_FLUSH;
                    end else if (me_load_hit_store) begin
                        wb_restart    <= 1'b1;
                        wb_restart_pc <= me_pc;
                        r_flush_cnt   <= CW'(DEPTH);
                        r_state       <= ST_FLUSH;
                    end else if (w_irq) begin
                        wb_trap       <= 1'b1;
                        wb_mcause     <= CAUSE_M_TIMER_IRQ;
                        wb_mepc       <= me_pc;
                        wb_mtval      <= '0;
                        wb_restart    <= 1'b1;
                        wb_restart_pc <= trap_vector(csr_mtvec);
                        r_flush_cnt   <= CW'(DEPTH);
                        r_state       <= ST_FLUSH;
                    end else if (me_valid) begin
                        wb_we  <= (me_wb_rd != '0);
                        wb_rd  <= me_wb_rd;
                        wb_val <= me_wb_val;
                    end
                end

                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - CW'(1);
                    if (r_flush_cnt <= CW'(1)) begin
                        r_state <= ST_RUN;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    yarvi_counter64 u_instret (
        .clk     (clock),
        .rst_n   (reset),
        .i_inc   (w_retire),
        .o_count (wb_instret)
    );

endmodule

// File: tb/tb_yarvi_wb.sv
// Self-checking bench for yarvi_wb: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_yarvi_wb;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        me_valid = 1'b0;
    logic [31:0] me_pc = '0;
    logic [4:0]  me_wb_rd = '0;
    logic [31:0] me_wb_val = '0;
    logic        me_store = 1'b0;
    logic        me_exc_misaligned = 1'b0;
    logic [31:0] me_exc_mtval = '0;
    logic        me_load_hit_store = 1'b0;
    logic        me_timer_interrupt = 1'b0;
    logic        csr_mie = 1'b0;
    logic [31:0] csr_mtvec = '0;

    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_val;
    logic        wb_restart;
    logic [31:0] wb_restart_pc;
    logic        wb_trap;
    logic [31:0] wb_mcause;
    logic [31:0] wb_mepc;
    logic [31:0] wb_mtval;
    logic [63:0] wb_instret;

    yarvi_wb #(.FLUSH_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock              (clock),
        .reset              (reset),
        .me_valid           (me_valid),
        .me_pc              (me_pc),
        .me_wb_rd           (me_wb_rd),
        .me_wb_val          (me_wb_val),
        .me_store           (me_store),
        .me_exc_misaligned  (me_exc_misaligned),
        .me_exc_mtval       (me_exc_mtval),
        .me_load_hit_store  (me_load_hit_store),
        .me_timer_interrupt (me_timer_interrupt),
        .csr_mie            (csr_mie),
        .csr_mtvec          (csr_mtvec),
        .wb_we              (wb_we),
        .wb_rd              (wb_rd),
        .wb_val             (wb_val),
        .wb_restart         (wb_restart),
        .wb_restart_pc      (wb_restart_pc),
        .wb_trap            (wb_trap),
        .wb_mcause          (wb_mcause),
        .wb_mepc            (wb_mepc),
        .wb_mtval           (wb_mtval),
        .wb_instret         (wb_instret)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: a restart is owed after reset; squash_left counts ignored cycles.
    bit          m_boot;
    int          m_squash;
    longint unsigned m_instret;
    bit          e_we, e_restart, e_trap;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rpc, e_cause, e_epc, e_tval;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot    = 1'b1;
        m_squash  = 0;
        m_instret = 0;
    endtask

    task automatic model_cycle();
        e_we = 0; e_restart = 0; e_trap = 0;
        e_rd = 'x; e_val = 'x; e_rpc = 'x; e_cause = 'x; e_epc = 'x; e_tval = 'x;
        if (m_boot) begin
            e_restart = 1; e_rpc = RST_PC;
            m_boot = 0; m_squash = DEPTH;
        end else if (m_squash > 0) begin
            m_squash--;
        end else if (me_exc_misaligned) begin
            e_trap = 1; e_cause = me_store ? 32'd6 : 32'd4;
            e_epc = me_pc; e_tval = me_exc_mtval;
            e_restart = 1; e_rpc = {csr_mtvec[31:2], 2'b00};
            m_squash = DEPTH;
        end else if (me_load_hit_store) begin
            e_restart = 1; e_rpc = me_pc;
            m_squash = DEPTH;
        end else if (csr_mie && me_timer_interrupt && me_valid && !me_store) begin
            e_trap = 1; e_cause = 32'h8000_0007; e_epc = me_pc; e_tval = 0;
            e_restart = 1; e_rpc = {csr_mtvec[31:2], 2'b00};
            m_squash = DEPTH;
        end else if (me_valid) begin
            m_instret++;
            e_we = (me_wb_rd != 0);
            e_rd = me_wb_rd; e_val = me_wb_val;
        end
    endtask

    task automatic step(input string tag);
        model_cycle();
        @(posedge clock);
        #1;
        chk({tag, ".we"},      64'(wb_we),      64'(e_we));
        chk({tag, ".restart"}, 64'(wb_restart), 64'(e_restart));
        chk({tag, ".trap"},    64'(wb_trap),    64'(e_trap));
        chk({tag, ".instret"}, wb_instret,      m_instret);
        if (e_we) begin
            chk({tag, ".rd"},  64'(wb_rd),  64'(e_rd));
            chk({tag, ".val"}, 64'(wb_val), 64'(e_val));
        end
        if (e_restart) chk({tag, ".restart_pc"}, 64'(wb_restart_pc), 64'(e_rpc));
        if (e_trap) begin
            chk({tag, ".mcause"}, 64'(wb_mcause), 64'(e_cause));
            chk({tag, ".mepc"},   64'(wb_mepc),   64'(e_epc));
            chk({tag, ".mtval"},  64'(wb_mtval),  64'(e_tval));
        end
    endtask

    task automatic idle_inputs();
        me_valid = 0; me_store = 0; me_exc_misaligned = 0;
        me_load_hit_store = 0; me_timer_interrupt = 0; me_wb_rd = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".we"},      64'(wb_we),         64'd0);
        chk({tag, ".rd"},      64'(wb_rd),         64'd0);
        chk({tag, ".val"},     64'(wb_val),        64'd0);
        chk({tag, ".restart"}, 64'(wb_restart),    64'd0);
        chk({tag, ".rpc"},     64'(wb_restart_pc), 64'd0);
        chk({tag, ".trap"},    64'(wb_trap),       64'd0);
        chk({tag, ".mcause"},  64'(wb_mcause),     64'd0);
        chk({tag, ".mepc"},    64'(wb_mepc),       64'd0);
        chk({tag, ".mtval"},   64'(wb_mtval),      64'd0);
        chk({tag, ".instret"}, wb_instret,         64'd0);
    endtask

    initial begin
        // Reset state, held across several edges.
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");

        // Release away from the edge; boot restart then three squashed cycles.
        reset = 1;
        me_valid = 1; me_wb_rd = 5'd7; me_wb_val = 32'hdead_beef;
        step("boot");
        for (int unsigned i = 0; i < 3; i++) step("boot_flush");

        // Normal retire with and without a destination.
        me_valid = 1; me_wb_rd = 5'd5; me_wb_val = 32'h1234; me_pc = 32'h8000_0010;
        step("retire_rd5");
        me_wb_rd = 5'd0; me_wb_val = 32'h5678;
        step("retire_rd0");

        // Misaligned store fault.
        me_store = 1; me_exc_misaligned = 1; me_exc_mtval = 32'h8000_0003;
        me_pc = 32'h8000_0100; csr_mtvec = 32'h8000_0041;
        step("misaligned");
        chk("misaligned.vector", 64'(wb_restart_pc), 64'h8000_0040);
        idle_inputs();
        for (int unsigned i = 0; i < 3; i++) step("mis_flush");

        // Load-hit-store replay, then a fault in the squash window is ignored.
        me_valid = 1; me_load_hit_store = 1; me_pc = 32'h8000_0200; me_wb_rd = 5'd3;
        step("lhs");
        me_load_hit_store = 0; me_exc_misaligned = 1; me_exc_mtval = 32'h8000_0201;
        step("lhs_ignored_fault");
        idle_inputs();
        step("lhs_flush");
        step("lhs_flush");

        // Interrupt pending over a store is deferred to the following load.
        csr_mie = 1; me_timer_interrupt = 1; csr_mtvec = 32'h8000_1000;
        me_valid = 1; me_store = 1; me_pc = 32'h8000_0300; me_wb_rd = 5'd0;
        step("irq_store");
        me_store = 0; me_pc = 32'h8000_0304; me_wb_rd = 5'd9; me_wb_val = 32'h99;
        step("irq_load");
        me_timer_interrupt = 0;
        for (int unsigned i = 0; i < 3; i++) step("irq_flush");

        // Counter wrap.
        force dut.u_instret.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_instret.r_count;
        #1;
        chk("wrap.preset", wb_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        me_valid = 1; me_wb_rd = 5'd1; me_wb_val = 32'h1;
        step("wrap");

        // Random traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            me_valid           = ($urandom_range(0, 3) != 0);
            me_pc              = $urandom() & ~32'h3;
            me_wb_rd           = 5'($urandom());
            me_wb_val          = $urandom();
            me_store           = ($urandom_range(0, 3) == 0);
            me_exc_misaligned  = me_valid && ($urandom_range(0, 19) == 0);
            me_exc_mtval       = $urandom();
            me_load_hit_store  = me_valid && ($urandom_range(0, 14) == 0);
            me_timer_interrupt = ($urandom_range(0, 5) == 0);
            csr_mie            = $urandom_range(0, 1) == 1;
            csr_mtvec          = $urandom();
            step("rand");
        end

        // Reset asserted mid-squash abandons everything.
        idle_inputs();
        me_valid = 1; me_exc_misaligned = 1; me_exc_mtval = 32'h11;
        step("pre_reset_trap");
        idle_inputs();
        step("pre_reset_flush");
        #2;
        reset = 0;
        #1;
        chk_reset_outputs("async_reset");
        me_valid = 1; me_exc_misaligned = 1;
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk("in_reset.restart", 64'(wb_restart), 64'd0);
            chk("in_reset.trap",    64'(wb_trap),    64'd0);
        end
        idle_inputs();
        reset = 1;
        model_reset();
        me_valid = 1; me_wb_rd = 5'd4;
        step("reboot");
        for (int unsigned i = 0; i < 4; i++) step("reboot_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
